// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared types and the reference operator for logic_op_pipe.
//   op_e      : operation select encoding (XOR/AND/OR/XNOR).
//   OP_MAX_W  : widest operand apply_op handles; callers zero-extend narrower
//               operands and keep the low bits of the result.
//   apply_op  : bitwise a op b, used by the RTL datapath and by reference models.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

  localparam int unsigned OP_MAX_W = 64;

  function automatic logic [OP_MAX_W-1:0] apply_op(
    input logic [OP_MAX_W-1:0] a,
    input logic [OP_MAX_W-1:0] b,
    input op_e                 op
  );
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XNOR: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/logic_op_pipe_stage.sv
// pipe_stage: one valid/payload register slice of an elastic pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   up_valid   : upstream slice (or input) holds a beat
//   up_data    : upstream payload
//   ready_dn   : downstream can take this slice's beat
//   ready_up   : this slice can take a beat (empty, or draining this cycle)
//   valid/data : registered beat presented downstream
module pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          ready_dn,
  output logic          ready_up,
  output logic          valid,
  output logic [PW-1:0] data
);

  assign ready_up = !valid || ready_dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready_up) begin
      valid <= up_valid;
      // Payload only moves with a real beat, so an empty slot keeps its last value.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: STAGES-deep registered pipeline computing a bitwise op of two
// WIDTH-bit operands, with valid/ready on both sides and a wrapping count of
// delivered results.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_a, in_b, in_op     : operands and op select (0 XOR, 1 AND, 2 OR, 3 XNOR)
//   out_valid/out_ready   : output handshake
//   out_data, out_op      : result and the op that produced it
//   out_count             : results delivered since reset, modulo 2^COUNT_W
//   out_parity            : XOR-reduction of out_data (only with
//                           LOGIC_OP_PIPE_PARITY_EN defined)
// WIDTH must not exceed logic_op_pkg::OP_MAX_W.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_op,
  output logic [COUNT_W-1:0] out_count
`ifdef LOGIC_OP_PIPE_PARITY_EN
  ,
  output logic               out_parity
`endif
);

`ifdef LOGIC_OP_PIPE_PARITY_EN
  localparam int unsigned PW = WIDTH + 3;
`else
  localparam int unsigned PW = WIDTH + 2;
`endif

  logic [WIDTH-1:0] result;
  logic [STAGES:0]  vld;
  logic [PW-1:0]    pay [STAGES+1];

  assign result = WIDTH'(apply_op(OP_MAX_W'(in_a), OP_MAX_W'(in_b), op_e'(in_op)));

  // Payload layout: {[parity,] op, data}. Parity is formed at the input and
  // carried along so the last stage registers it together with the data.
`ifdef LOGIC_OP_PIPE_PARITY_EN
  assign pay[0] = {^result, in_op, result};
`else
  assign pay[0] = {in_op, result};
`endif
  assign vld[0] = in_valid;

  // Each slice keeps its own ready signals so the backward ready chain is a
  // sequence of distinct nets rather than one self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic rdy_up;
    logic rdy_dn;

    if (k == STAGES - 1) begin : g_last
      assign rdy_dn = out_ready;
    end else begin : g_mid
      assign rdy_dn = g_st[k+1].rdy_up;
    end

    pipe_stage #(
      .PW(PW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k]),
      .up_data  (pay[k]),
      .ready_dn (rdy_dn),
      .ready_up (rdy_up),
      .valid    (vld[k+1]),
      .data     (pay[k+1])
    );
  end

  assign in_ready  = g_st[0].rdy_up;
  assign out_valid = vld[STAGES];
  assign out_data  = pay[STAGES][WIDTH-1:0];
  assign out_op    = pay[STAGES][WIDTH+1:WIDTH];
`ifdef LOGIC_OP_PIPE_PARITY_EN
  assign out_parity = pay[STAGES][WIDTH+2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed bench for logic_op_pipe (WIDTH=8, STAGES=2,
// COUNT_W=4). Define LOGIC_OP_PIPE_PARITY_EN to also cover out_parity.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_op;
  logic [COUNT_W-1:0] out_count;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic               out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected beats in delivery order: {op, data}.
  logic [9:0] expq [$];

  always #5 clk = ~clk;

  logic_op_pipe #(
    .WIDTH   (WIDTH),
    .STAGES  (STAGES),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_count  (out_count)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [OP_MAX_W-1:0] r;
    r = apply_op(OP_MAX_W'(a), OP_MAX_W'(b), op_e'(op));
    return r[7:0];
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  // Called just after a rising edge with inputs already driven; records both
  // handshakes for this cycle, then advances to just after the next edge.
  task automatic tick();
    logic [9:0] e;
    #1;
    if (out_valid === 1'b1 && out_ready) begin
      check("beat_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("order_data", 32'(out_data), 32'(e[7:0]));
        check("order_op", 32'(out_op), 32'(e[9:8]));
`ifdef LOGIC_OP_PIPE_PARITY_EN
        check("order_parity", 32'(out_parity), 32'(^e[7:0]));
`endif
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      expq.push_back({in_op, ref_op(in_a, in_b, in_op)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic single_beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                             input logic [7:0] expd, input logic [3:0] expcnt);
    drive(a, b, op);
    tick();
    in_valid = 1'b0;
    check("single_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'(expd));
    check("single_op", 32'(out_op), 32'(op));
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("single_parity", 32'(out_parity), 32'(^expd));
`endif
    tick();
    check("single_count", 32'(out_count), 32'(expcnt));
    check("single_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int accepted;
    logic [7:0] hold_d;
    logic [1:0] hold_op;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // 1: one beat per op, latency STAGES, count steps by one
    single_beat(8'hF0, 8'h3C, 2'd0, 8'hCC, 4'd1);
    single_beat(8'hF0, 8'h3C, 2'd1, 8'h30, 4'd2);
    single_beat(8'hF0, 8'h3C, 2'd2, 8'hFC, 4'd3);
    single_beat(8'hF0, 8'h3C, 2'd3, 8'h33, 4'd4);

    // 2: 16 back-to-back random beats
    for (int i = 0; i < 16; i++) begin
      drive(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_empty", 32'(expq.size()), 32'd0);
    check("stream_count", 32'(out_count), 32'd4);

    // 3: backpressure fills exactly STAGES slots, then holds and drains
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(8'hA0 + i), 8'h5A, 2'(i));
      #1;
      if (in_ready !== 1'b1) break;
      tick();
      accepted++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'(STAGES));
    hold_d  = out_data;
    hold_op = out_op;
    check("bp_head_data", 32'(hold_d), 32'(expq[0][7:0]));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(hold_d));
      check("bp_hold_op", 32'(out_op), 32'(hold_op));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    check("bp_empty", 32'(expq.size()), 32'd0);
    check("bp_count", 32'(out_count), 32'd6);

    // 4: full pipe with both sides active moves one beat per cycle
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(8'(8'h40 + i), 8'hC3, 2'(i + 1));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(8'(8'h81 + 3 * i), 8'h96, 2'(i));
      #1;
      check("full_in_ready", 32'(in_ready), 32'd1);
      check("full_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("full_empty", 32'(expq.size()), 32'd0);
    check("full_count", 32'(out_count), 32'd14);

    // 5: counter wraps modulo 2^COUNT_W
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(8'($urandom), 8'($urandom), 2'(i));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("wrap_empty", 32'(expq.size()), 32'd0);
    check("wrap_count", 32'(out_count), 32'd1);

    // 6: reset with two beats in flight
    drive(8'h11, 8'h22, 2'd0);
    tick();
    drive(8'h33, 8'h44, 2'd2);
    tick();
    check("inflight_valid", 32'(out_valid), 32'd1);
    do_reset();
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_no_stale2", 32'(out_valid), 32'd0);
    single_beat(8'h0F, 8'h3E, 2'd1, 8'h0E, 4'd1);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    single_beat(8'h30, 8'h01, 2'd2, 8'h31, 4'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
